// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// spi_pkg
// ----------------------------------------------------------------------------
// Shared types and constants for the SPI master arbiter: the controller state
// encoding, the default transfer width and the mode-0 clock-level constants.
// Revision: 1.0
// ============================================================================
package spi_pkg;

  // Controller states; explicit width keeps the encoding stable across tools.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int SPI_DATA_W = 8;

  // Mode 0: SCLK idles low, data is sampled on the rising (active) edge and
  // launched on the falling edge.
  localparam logic SCLK_IDLE   = 1'b0;
  localparam logic SCLK_ACTIVE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/spi_master_arbiter_rr.sv
`default_nettype none
// ============================================================================
// rr_arbiter
// ----------------------------------------------------------------------------
// Purely combinational round-robin selector. Picks the first asserted request
// at or after the pointer position, wrapping around the request vector.
// Ports:
//   req   - request vector
//   ptr   - highest-priority requester index (kept by the caller)
//   gnt   - one-hot winner (all zero when no request)
//   idx   - binary index of the winner
//   valid - at least one request is asserted
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [NUM_REQ-1:0] rot;
  int                 win;

  always_comb begin
    // Rotating the doubled vector puts the pointer position at bit 0, so a
    // plain lowest-set-bit search gives round-robin order.
    rot   = NUM_REQ'({req, req} >> ptr);
    valid = 1'b0;
    win   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        win   = int'(ptr) + k;
      end
    end
    if (win >= NUM_REQ) win = win - NUM_REQ;
    gnt = '0;
    for (int j = 0; j < NUM_REQ; j++) gnt[j] = valid && (win == j);
    idx = IDX_W'(win);
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// spi_master_arbiter
// ----------------------------------------------------------------------------
// Mode-0 SPI master shared by NUM_REQ requesters with round-robin arbitration.
// Each grant performs one DATA_W-bit full-duplex transfer, MSB first, on the
// requested chip select and returns the received word.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   req         - level request per requester, held until done
//   req_cs_sel  - packed chip-select index per requester
//   req_data    - packed transmit word per requester
//   gnt         - one-hot pulse when a request is captured
//   done        - one-hot pulse when that transfer completes
//   rx_data     - received word, valid from done until the next done
//   busy        - controller is not idle
//   sclk, cs_n, mosi, miso - SPI bus
// Revision: 1.0
// ============================================================================
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int NUM_CS  = 2,
  parameter  int CLK_DIV = 4,
  parameter  int DATA_W  = SPI_DATA_W,
  localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*CS_W-1:0]   req_cs_sel,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
  output logic                      sclk,
  output logic [NUM_CS-1:0]         cs_n,
  output logic                      mosi,
  input  logic                      miso
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t             state;
  logic [DIV_W-1:0]   div;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DATA_W-2:0]  tx_rest;   // bits still to send after the one on mosi
  logic [DATA_W-1:0]  rx_shift;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   ptr;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [DATA_W-1:0]  pick_data;
  logic [NUM_CS-1:0]  pick_cs_n;
  logic               div_last;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Winner's transmit word and chip-select pattern; an out-of-range index
  // leaves every select high.
  always_comb begin
    pick_data = '0;
    pick_cs_n = '1;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (arb_gnt[r]) begin
        pick_data = req_data[r*DATA_W +: DATA_W];
        for (int c = 0; c < NUM_CS; c++) begin
          if (int'(req_cs_sel[r*CS_W +: CS_W]) == c) pick_cs_n[c] = 1'b0;
        end
      end
    end
  end

  assign div_last = (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      div      <= '0;
      bit_cnt  <= '0;
      tx_rest  <= '0;
      rx_shift <= '0;
      owner    <= '0;
      ptr      <= '0;
      gnt      <= '0;
      done     <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      sclk     <= SCLK_IDLE;
      cs_n     <= '1;
      mosi     <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      div  <= (state == ST_IDLE || div_last) ? '0 : div + 1'b1;

      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt     <= arb_gnt;
            owner   <= arb_idx;
            ptr     <= (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
            mosi    <= pick_data[DATA_W-1];
            tx_rest <= pick_data[DATA_W-2:0];
            cs_n    <= pick_cs_n;
            busy    <= 1'b1;
            state   <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (div_last) begin
            bit_cnt <= '0;
            state   <= ST_XFER;
          end
        end

        ST_XFER: begin
          if (div_last) begin
            if (sclk == SCLK_IDLE) begin
              sclk     <= SCLK_ACTIVE;
              rx_shift <= {rx_shift[DATA_W-2:0], miso};
            end else begin
              sclk <= SCLK_IDLE;
              if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                state <= ST_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                mosi    <= tx_rest[DATA_W-2];
                tx_rest <= tx_rest << 1;
              end
            end
          end
        end

        ST_HOLD: begin
          if (div_last) begin
            rx_data <= rx_shift;
            done    <= NUM_REQ'(1) << owner;
            cs_n    <= '1;
            state   <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (div_last) begin
            busy  <= 1'b0;
            mosi  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spi_master_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench. Main instance: 2 requesters, 3 selects (so index 3 is
// out of range), CLK_DIV=4. Second instance: 1 requester, CLK_DIV=2, miso
// tied low, used for SCLK phase timing.
// Revision: 1.0
// ============================================================================
module tb_spi_master_arbiter;

  localparam int NR    = 2;
  localparam int NC    = 3;
  localparam int CD    = 4;
  localparam int DW    = 8;
  localparam int CSW   = 2;
  localparam int LAT   = (2*DW + 2) * CD;
  localparam int CD2   = 2;
  localparam int LAT2  = (2*DW + 2) * CD2;
  localparam int DBUS  = NR * DW;
  localparam int CSBUS = NR * CSW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req = '0;
  logic [CSBUS-1:0] req_cs_sel = '0;
  logic [DBUS-1:0]  req_data = '0;
  logic [NR-1:0]    gnt, done;
  logic [DW-1:0]    rx_data;
  logic             busy, sclk, mosi;
  logic             miso = 1'b0;
  logic [NC-1:0]    cs_n;

  logic [0:0]       req2 = '0;
  logic [0:0]       cs2_sel = '0;
  logic [DW-1:0]    data2 = '0;
  logic [0:0]       gnt2, done2, cs2_n;
  logic [DW-1:0]    rx2;
  logic             busy2, sclk2, mosi2;

  spi_master_arbiter #(.NUM_REQ(NR), .NUM_CS(NC), .CLK_DIV(CD), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cs_sel(req_cs_sel), .req_data(req_data),
    .gnt(gnt), .done(done), .rx_data(rx_data), .busy(busy), .sclk(sclk),
    .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_master_arbiter #(.NUM_REQ(1), .NUM_CS(1), .CLK_DIV(CD2), .DATA_W(DW)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_cs_sel(cs2_sel), .req_data(data2),
    .gnt(gnt2), .done(done2), .rx_data(rx2), .busy(busy2), .sclk(sclk2),
    .cs_n(cs2_n), .mosi(mosi2), .miso(1'b0)
  );

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;       // reference round-robin pointer
  logic [DW-1:0] resp = '0;

  // Slave model: presents the response MSB when a transfer starts and the
  // next bit after every falling SCLK edge.
  int   sidx = 0;
  logic psclk_s = 1'b0;
  always @(negedge clk) begin
    if (gnt != '0) begin
      sidx = 0;
      miso = resp[DW-1];
    end else if (psclk_s && !sclk) begin
      sidx++;
      miso = (sidx < DW) ? resp[DW-1-sidx] : 1'b0;
    end
    psclk_s = sclk;
  end

  // Reference arbitration: first asserted requester at or after the pointer.
  function automatic int predict(input logic [NR-1:0] r);
    for (int k = 0; k < NR; k++) begin
      if (r[(ptr_m + k) % NR]) begin
        ptr_m = ((ptr_m + k) % NR + 1) % NR;
        return (ptr_m + NR - 1) % NR;
      end
    end
    return -1;
  endfunction

  // Waits for the grant and follows one transfer on the main instance.
  task automatic observe(input int exp_idx, input logic [DW-1:0] exp_tx, input int exp_cs,
                         input logic [DW-1:0] exp_rx, input bit drop, input bit scramble,
                         input string name, output int waited);
    int cyc, rises, cs_bad, busy_bad;
    bit seen, got_done;
    logic pscl;
    logic [DW-1:0] got_mosi;
    logic [NC-1:0] exp_csn;
    exp_csn = '1;
    if (exp_cs < NC) exp_csn[exp_cs] = 1'b0;
    waited = 0; seen = 0; cs_bad = 0; busy_bad = 0; rises = 0; got_mosi = '0;
    while (!seen && waited < 300) begin
      @(negedge clk);
      if (gnt != '0) seen = 1;
      else begin
        waited++;
        if (cs_n !== '1) cs_bad++;
      end
    end
    checks++;
    if (gnt !== (NR'(1) << exp_idx)) begin
      errors++;
      $display("FAIL %s gnt: got %b want %b", name, gnt, NR'(1) << exp_idx);
    end
    if (scramble) begin
      req_data   = DBUS'($urandom);
      req_cs_sel = CSBUS'($urandom);
    end
    pscl = sclk; cyc = 0; got_done = 0;
    while (!got_done && cyc < LAT + 20) begin
      @(negedge clk);
      cyc++;
      if (drop && cyc == 1) req[exp_idx] = 1'b0;
      if (done != '0) got_done = 1;
      else begin
        if (cs_n !== exp_csn) cs_bad++;
        if (busy !== 1'b1) busy_bad++;
        if (sclk && !pscl) begin
          rises++;
          got_mosi = {got_mosi[DW-2:0], mosi};
        end
        pscl = sclk;
      end
    end
    checks++;
    if (cyc != LAT) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, LAT); end
    checks++;
    if (done !== (NR'(1) << exp_idx)) begin errors++; $display("FAIL %s done: got %b want %b", name, done, NR'(1) << exp_idx); end
    checks++;
    if (rx_data !== exp_rx) begin errors++; $display("FAIL %s rx_data: got %h want %h", name, rx_data, exp_rx); end
    checks++;
    if (got_mosi !== exp_tx || rises != DW) begin
      errors++;
      $display("FAIL %s mosi: got %h over %0d rises want %h over %0d", name, got_mosi, rises, exp_tx, DW);
    end
    checks++;
    if (cs_bad != 0 || cs_n !== '1) begin errors++; $display("FAIL %s cs_n: %0d bad cycles, at done %b want all ones", name, cs_bad, cs_n); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL %s busy: low in %0d transfer cycles want 0", name, busy_bad); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (gnt !== '0 || done !== '0 || rx_data !== '0 || busy !== 1'b0 ||
        sclk !== 1'b0 || cs_n !== '1 || mosi !== 1'b0) begin
      errors++;
      $display("FAIL reset: got gnt=%b done=%b rx=%h busy=%b sclk=%b cs_n=%b mosi=%b want 0,0,00,0,0,111,0",
               gnt, done, rx_data, busy, sclk, cs_n, mosi);
    end
    checks++;
    if (busy2 !== 1'b0 || sclk2 !== 1'b0 || cs2_n !== 1'b1 || rx2 !== '0) begin
      errors++;
      $display("FAIL reset2: got busy=%b sclk=%b cs_n=%b rx=%h want 0,0,1,00", busy2, sclk2, cs2_n, rx2);
    end
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int w, waited;
    req_data[0 +: DW]   = 8'hA5;
    req_cs_sel[0 +: CSW] = 2'd1;
    resp = 8'h3C;
    req = 2'b01;
    w = predict(req);
    observe(w, 8'hA5, 1, 8'h3C, 0, 0, "single", waited);
    req = '0;
  endtask

  task automatic test_back_to_back();
    int w, waited;
    logic [DW-1:0] d [NR];
    int cs [NR];
    d[0] = 8'h5A; d[1] = 8'hC3; cs[0] = 0; cs[1] = 2;
    for (int r = 0; r < NR; r++) begin
      req_data[r*DW +: DW]    = d[r];
      req_cs_sel[r*CSW +: CSW] = CSW'(cs[r]);
    end
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      resp = DW'($urandom);
      w = predict(req);
      observe(w, d[w], cs[w], resp, 0, 0, "b2b", waited);
      if (t > 0) begin
        checks++;
        if (waited != CD) begin errors++; $display("FAIL b2b gap: got %0d idle cycles want %0d", waited, CD); end
      end
    end
    req = '0;
  endtask

  task automatic test_out_of_range();
    int w, waited;
    req_data[0 +: DW]    = 8'h96;
    req_cs_sel[0 +: CSW] = 2'd3;
    resp = 8'hE1;
    req = 2'b01;
    w = predict(req);
    observe(w, 8'h96, 3, 8'hE1, 0, 0, "cs_oor", waited);
    req = '0;
  endtask

  task automatic test_drop();
    int w, waited, regrants;
    req_data[0 +: DW]    = 8'h1F;
    req_cs_sel[0 +: CSW] = 2'd0;
    resp = 8'h80;
    req = 2'b01;
    w = predict(req);
    observe(w, 8'h1F, 0, 8'h80, 1, 0, "drop", waited);
    regrants = 0;
    repeat (30) begin
      @(negedge clk);
      if (gnt != '0) regrants++;
    end
    checks++;
    if (regrants != 0) begin errors++; $display("FAIL drop regrant: got %0d grants want 0", regrants); end
  endtask

  task automatic test_random();
    int w, waited;
    logic [DW-1:0] d [NR];
    int cs [NR];
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < NR; r++) begin
        d[r]  = DW'($urandom);
        cs[r] = $urandom_range(0, 3);
        req_data[r*DW +: DW]    = d[r];
        req_cs_sel[r*CSW +: CSW] = CSW'(cs[r]);
      end
      resp = DW'($urandom);
      req  = NR'($urandom_range(1, 3));
      w = predict(req);
      observe(w, d[w], cs[w], resp, 0, 1, "random", waited);
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    int w, waited, n, rises, stray;
    logic p;
    req_data[1*DW +: DW]    = 8'h77;
    req_cs_sel[1*CSW +: CSW] = 2'd0;
    resp = 8'h0F;
    req = 2'b10;
    w = predict(req);
    n = 0;
    while (gnt == '0 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (gnt !== (NR'(1) << w)) begin errors++; $display("FAIL rstmid gnt: got %b want %b", gnt, NR'(1) << w); end
    rises = 0; p = sclk; n = 0;
    while (rises < 5 && n < LAT) begin
      @(negedge clk); n++;
      if (sclk && !p) rises++;
      p = sclk;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cs_n !== '1 || sclk !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid outputs: got cs_n=%b sclk=%b busy=%b want 111,0,0", cs_n, sclk, busy);
    end
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (done != '0 || gnt != '0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL rstmid done: got %0d pulses in reset want 0", stray); end
    rst_n = 1'b1;
    ptr_m = 0;
    resp = 8'hB4;
    w = predict(req);
    observe(w, 8'h77, 0, 8'hB4, 0, 0, "rstmid_after", waited);
    req = '0;
  endtask

  task automatic test_fast();
    logic [DW-1:0] pat [2];
    pat[0] = 8'hFF; pat[1] = 8'h00;
    req2 = 1'b1;
    for (int t = 0; t < 2; t++) begin
      int n, cyc, rises, hi_run, lo_run, bad_phase, cs_bad;
      bit seen_rise;
      logic p;
      logic [DW-1:0] got;
      data2 = pat[t];
      n = 0;
      while (gnt2 == 1'b0 && n < 300) begin @(negedge clk); n++; end
      checks++;
      if (gnt2 !== 1'b1) begin errors++; $display("FAIL fast gnt: got %b want 1", gnt2); end
      cyc = 0; rises = 0; hi_run = 0; lo_run = 0; bad_phase = 0; cs_bad = 0;
      seen_rise = 0; p = sclk2; got = '0;
      while (done2 == 1'b0 && cyc < LAT2 + 20) begin
        @(negedge clk); cyc++;
        if (done2 == 1'b0) begin
          if (cs2_n !== 1'b0) cs_bad++;
          if (sclk2) begin
            if (!p) begin
              if (seen_rise && lo_run != CD2) bad_phase++;
              seen_rise = 1; rises++; hi_run = 0;
              got = {got[DW-2:0], mosi2};
            end
            hi_run++;
          end else begin
            if (p) begin
              if (hi_run != CD2) bad_phase++;
              lo_run = 0;
            end
            lo_run++;
          end
          p = sclk2;
        end
      end
      checks++;
      if (cyc != LAT2) begin errors++; $display("FAIL fast latency: got %0d want %0d", cyc, LAT2); end
      checks++;
      if (rises != DW || bad_phase != 0) begin
        errors++;
        $display("FAIL fast sclk: got %0d rises, %0d bad phases want %0d rises, 0 bad", rises, bad_phase, DW);
      end
      checks++;
      if (got !== pat[t] || rx2 !== 8'h00 || cs_bad != 0) begin
        errors++;
        $display("FAIL fast data: got mosi=%h rx=%h cs_bad=%0d want mosi=%h rx=00 cs_bad=0", got, rx2, cs_bad, pat[t]);
      end
    end
    req2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_range();
    test_drop();
    test_random();
    test_reset_mid();
    test_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
